// File: rtl/cpu_lv1_stub_responder.sv
// Stand-in L1 answering CPU cpu_rd/cpu_wr from a small register store; latency LATENCY+1 edges from capture to response.
// Backpressure: the CPU holds its request until the response is seen; CPU_STUB_LFSR_LAT_EN adds 0..7 random wait cycles.
module cpu_lv1_stub_responder #(
    parameter int DATA_WID_LV1 = 32,
    parameter int ADDR_WID_LV1 = 32,
    parameter int IDX_WID      = 4,
    parameter int LATENCY      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cpu_rd,
    input  logic                    cpu_wr,
    input  logic [ADDR_WID_LV1-1:0] addr_bus_cpu_lv1,
    inout  wire  [DATA_WID_LV1-1:0] data_bus_cpu_lv1,
    output logic                    data_in_bus_cpu_lv1,
    output logic                    cpu_wr_done,
    output logic                    busy,
    output logic                    protocol_err,
    output logic [15:0]             txn_count
);
    localparam int DEPTH = 2 ** IDX_WID;
    localparam int CNT_W = 9;

    typedef enum logic [1:0] {IDLE, WAIT, DONE_RD, DONE_WR} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_WID-1:0]      idx_q, idx_d;
    logic                    op_wr_q, op_wr_d;
    logic [DATA_WID_LV1-1:0] wdata_q, wdata_d;
    logic [DATA_WID_LV1-1:0] rdata_q, rdata_d;
    logic                    rd_vld_q, rd_vld_d;
    logic                    wr_done_q, wr_done_d;
    logic                    busy_q, busy_d;
    logic                    perr_q, perr_d;
    logic [15:0]             txn_q, txn_d;
    logic                    mem_we;
    logic [DATA_WID_LV1-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]        lat_load;

    // Upper address bits alias onto the same word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_bus_cpu_lv1[ADDR_WID_LV1-1:IDX_WID];

`ifdef CPU_STUB_LFSR_LAT_EN
    logic [7:0] lfsr_q;
    logic       lfsr_fb;

    // x^8+x^6+x^5+x^4+1, Fibonacci form.
    assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign lat_load = CNT_W'(LATENCY) + CNT_W'(lfsr_q[2:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 8'h5A;
        else        lfsr_q <= {lfsr_q[6:0], lfsr_fb};
    end
`else
    assign lat_load = CNT_W'(LATENCY);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        op_wr_d   = op_wr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rd_vld_d  = 1'b0;
        wr_done_d = 1'b0;
        perr_d    = 1'b0;
        txn_d     = txn_q;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_rd && cpu_wr) begin
                    perr_d = 1'b1;
                end else if (cpu_rd || cpu_wr) begin
                    idx_d   = addr_bus_cpu_lv1[IDX_WID-1:0];
                    op_wr_d = cpu_wr;
                    cnt_d   = lat_load;
                    state_d = WAIT;
                    if (cpu_wr) wdata_d = data_bus_cpu_lv1;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (op_wr_q) begin
                    mem_we    = 1'b1;
                    wr_done_d = 1'b1;
                    state_d   = DONE_WR;
                end else begin
                    rdata_d  = mem_q[idx_q];
                    rd_vld_d = 1'b1;
                    state_d  = DONE_RD;
                end
            end
            DONE_RD: begin
                if (cpu_rd) begin
                    rd_vld_d = 1'b1;
                end else begin
                    txn_d   = txn_q + 16'd1;
                    state_d = IDLE;
                end
            end
            DONE_WR: begin
                if (cpu_wr) begin
                    wr_done_d = 1'b1;
                end else begin
                    txn_d   = txn_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            op_wr_q   <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rd_vld_q  <= 1'b0;
            wr_done_q <= 1'b0;
            busy_q    <= 1'b0;
            perr_q    <= 1'b0;
            txn_q     <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            op_wr_q   <= op_wr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            rd_vld_q  <= rd_vld_d;
            wr_done_q <= wr_done_d;
            busy_q    <= busy_d;
            perr_q    <= perr_d;
            txn_q     <= txn_d;
            if (mem_we) mem_q[idx_q] <= wdata_q;
        end
    end

    assign data_bus_cpu_lv1    = rd_vld_q ? rdata_q : {DATA_WID_LV1{1'bz}};
    assign data_in_bus_cpu_lv1 = rd_vld_q;
    assign cpu_wr_done         = wr_done_q;
    assign busy                = busy_q;
    assign protocol_err        = perr_q;
    assign txn_count           = txn_q;
endmodule

// File: tb/tb_cpu_lv1_stub_responder.sv
// Directed bench for cpu_lv1_stub_responder; exercises the LFSR latency mode when CPU_STUB_LFSR_LAT_EN is defined.
module tb_cpu_lv1_stub_responder;
`ifdef CPU_STUB_LFSR_LAT_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] tb_dat = '0;
    logic        tb_drv = 1'b0;
    wire  [31:0] data_bus;
    logic        dvld, wdone, busy, perr;
    logic [15:0] txn;

    int n_pass = 0;
    int n_tot  = 0;

    assign data_bus = tb_drv ? tb_dat : 32'hzzzz_zzzz;

    cpu_lv1_stub_responder #(
        .DATA_WID_LV1(32), .ADDR_WID_LV1(32), .IDX_WID(4), .LATENCY(LAT)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .cpu_rd              (cpu_rd),
        .cpu_wr              (cpu_wr),
        .addr_bus_cpu_lv1    (addr),
        .data_bus_cpu_lv1    (data_bus),
        .data_in_bus_cpu_lv1 (dvld),
        .cpu_wr_done         (wdone),
        .busy                (busy),
        .protocol_err        (perr),
        .txn_count           (txn)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_dvld", 32'(dvld), 32'd0);
        chk("rst_wdone", 32'(wdone), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_perr", 32'(perr), 32'd0);
        chk("rst_txn", 32'(txn), 32'd0);
        rst_n = 1'b1;
        tick();

`ifndef CPU_STUB_LFSR_LAT_EN
        // Write idx 3
        cpu_wr = 1'b1; addr = 32'h3; tb_dat = 32'hDEADBEEF; tb_drv = 1'b1;
        tick();
        chk("wr_busy_capture", 32'(busy), 32'd1);
        chk("wr_done_capture", 32'(wdone), 32'd0);
        repeat (LAT) begin
            tick();
            chk("wr_done_early", 32'(wdone), 32'd0);
        end
        tick();
        chk("wr_done_rise", 32'(wdone), 32'd1);
        tick();
        chk("wr_done_held", 32'(wdone), 32'd1);
        cpu_wr = 1'b0; tb_drv = 1'b0;
        tick();
        chk("wr_done_fall", 32'(wdone), 32'd0);
        chk("wr_busy_fall", 32'(busy), 32'd0);
        chk("wr_txn", 32'(txn), 32'd1);

        // Read idx 3 through alias 0x13
        cpu_rd = 1'b1; addr = 32'h13;
        tick();
        repeat (LAT) begin
            tick();
            chk("rd_dvld_early", 32'(dvld), 32'd0);
        end
        tick();
        chk("rd_dvld_rise", 32'(dvld), 32'd1);
        chk("rd_data", data_bus, 32'hDEADBEEF);
        tick();
        chk("rd_data_held", data_bus, 32'hDEADBEEF);
        cpu_rd = 1'b0;
        tick();
        chk("rd_dvld_fall", 32'(dvld), 32'd0);
        chk("rd_txn", 32'(txn), 32'd2);
        // Bus released: the bench can drive it without contention
        tb_dat = 32'h5A5A0F0F; tb_drv = 1'b1;
        #1;
        chk("rd_bus_released", data_bus, 32'h5A5A0F0F);
        tb_drv = 1'b0;

        // Illegal simultaneous request
        cpu_rd = 1'b1; cpu_wr = 1'b1; addr = 32'h1;
        tick();
        chk("perr_pulse", 32'(perr), 32'd1);
        chk("perr_busy", 32'(busy), 32'd0);
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        tick();
        chk("perr_clear", 32'(perr), 32'd0);
        chk("perr_no_resp", 32'({dvld, wdone}), 32'd0);
        chk("perr_txn", 32'(txn), 32'd2);

        // One-cycle read pulse of idx 0
        cpu_rd = 1'b1; addr = 32'h0;
        tick();
        cpu_rd = 1'b0;
        repeat (LAT) tick();
        tick();
        chk("pulse_dvld", 32'(dvld), 32'd1);
        chk("pulse_data", data_bus, 32'h0);
        tick();
        chk("pulse_dvld_fall", 32'(dvld), 32'd0);
        chk("pulse_idle", 32'(busy), 32'd0);
        chk("pulse_txn", 32'(txn), 32'd3);

        // Reset during WAIT of a write to idx 5
        cpu_wr = 1'b1; addr = 32'h5; tb_dat = 32'h1234; tb_drv = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_wdone", 32'(wdone), 32'd0);
        chk("arst_txn", 32'(txn), 32'd0);
        cpu_wr = 1'b0; tb_drv = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        cpu_rd = 1'b1; addr = 32'h5;
        tick();
        repeat (LAT) tick();
        tick();
        chk("arst_rd_dvld", 32'(dvld), 32'd1);
        chk("arst_rd_data", data_bus, 32'h0);
        cpu_rd = 1'b0;
        tick();
        chk("arst_rd_txn", 32'(txn), 32'd1);
`else
        begin
            int lat_seen [16];
            int distinct;
            for (int i = 0; i < 16; i++) begin
                int k;
                cpu_rd = 1'b1; addr = 32'(i);
                tick();
                k = 0;
                while (!dvld && k < 20) begin
                    tick();
                    k++;
                end
                chk("lfsr_lat_range", 32'(k >= 3 && k <= 10), 32'd1);
                lat_seen[i] = k;
                cpu_rd = 1'b0;
                tick();
            end
            distinct = 0;
            for (int i = 1; i < 16; i++)
                if (lat_seen[i] != lat_seen[0]) distinct = 1;
            chk("lfsr_lat_distinct", 32'(distinct), 32'd1);
            chk("lfsr_txn", 32'(txn), 32'd16);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
